// File: rtl/vga_display_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_display_controller_if                                        |
// | Pixel fetch bus between the raster controller and a pixel source |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface vga_display_controller_if #(
  parameter int COLOR_BITS = 8
);
  logic                      pixel_req;
  logic [10:0]               next_pixel_h;
  logic [10:0]               next_pixel_v;
  logic [31:0]               next_pixel_addr;
  logic [3*COLOR_BITS-1:0]   pixel;

  modport master (
    output pixel_req, next_pixel_h, next_pixel_v, next_pixel_addr,
    input  pixel
  );

  modport slave (
    input  pixel_req, next_pixel_h, next_pixel_v, next_pixel_addr,
    output pixel
  );
endinterface
`default_nettype wire

// File: rtl/vga_display_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_display_controller                                           |
// | Parametrised raster timing, fetch-latency alignment, output mux  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module vga_display_controller #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int HS_POL        = 0,
  parameter int VS_POL        = 0,
  parameter int COLOR_BITS    = 8,
  parameter int FETCH_LATENCY = 1
) (
  input  logic                     vga_clk,
  input  logic                     reset,
  input  logic [1:0]               mode,
  input  logic [3*COLOR_BITS-1:0]  border_color,
  vga_display_controller_if.master fetch,
  output logic                     frame_start,
  output logic                     blank_n,
  output logic                     HS,
  output logic                     VS,
  output logic [COLOR_BITS-1:0]    red,
  output logic [COLOR_BITS-1:0]    green,
  output logic [COLOR_BITS-1:0]    blue
);

  localparam int          c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int          c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [10:0] c_H_LAST  = 11'(c_H_TOTAL - 1);
  localparam logic [10:0] c_V_LAST  = 11'(c_V_TOTAL - 1);
  localparam logic [10:0] c_BAR_W   = 11'((H_VISIBLE >= 8) ? (H_VISIBLE / 8) : 1);
  localparam logic        c_HS_ACT  = (HS_POL != 0);
  localparam logic        c_VS_ACT  = (VS_POL != 0);
  localparam int          c_DW      = 26;

  logic [10:0]             r_h;
  logic [10:0]             r_v;
  logic [1:0]              r_mode_active;
  logic                    w_origin;
  logic                    w_vis;
  logic                    w_hs_act;
  logic                    w_vs_act;
  logic                    w_fs;
  logic [c_DW-1:0]         w_tap0;
  logic [c_DW-1:0]         w_tapd;
  logic                    w_vis_d;
  logic                    w_hs_d;
  logic                    w_vs_d;
  logic                    w_fs_d;
  logic [10:0]             w_hd;
  logic [10:0]             w_vd;
  logic [1:0]              w_mode_use;
  logic [10:0]             w_bar_raw;
  logic [2:0]              w_bar;
  logic                    w_edge;
  logic [3*COLOR_BITS-1:0] w_rgb;

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == c_H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == c_V_LAST) ? 11'd0 : r_v + 11'd1;
    end else begin
      r_h <= r_h + 11'd1;
    end
  end

  assign w_origin = (r_h == 11'd0) && (r_v == 11'd0);
  assign w_vis    = (r_h < 11'(H_VISIBLE)) && (r_v < 11'(V_VISIBLE));
  assign w_hs_act = (r_h >= 11'(H_VISIBLE + H_FRONT)) && (r_h < 11'(H_VISIBLE + H_FRONT + H_SYNC));
  assign w_vs_act = (r_v >= 11'(V_VISIBLE + V_FRONT)) && (r_v < 11'(V_VISIBLE + V_FRONT + V_SYNC));
  assign w_fs     = w_origin && w_vis;

  assign fetch.pixel_req       = w_vis;
  assign fetch.next_pixel_h    = r_h;
  assign fetch.next_pixel_v    = r_v;
  assign fetch.next_pixel_addr = w_vis ? (32'(r_v) * 32'(H_VISIBLE) + 32'(r_h)) : 32'd0;

  // Mode only changes at the frame origin so a frame never mixes modes.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      r_mode_active <= 2'd0;
    end else if (w_origin) begin
      r_mode_active <= mode;
    end
  end

  assign w_tap0 = {w_vis, w_hs_act, w_vs_act, w_fs, r_h, r_v};

  generate
    if (FETCH_LATENCY == 0) begin : g_no_delay
      assign w_tapd = w_tap0;
    end else begin : g_delay
      logic [c_DW-1:0] r_dly [FETCH_LATENCY];
      always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < FETCH_LATENCY; i++) r_dly[i] <= '0;
        end else begin
          r_dly[0] <= w_tap0;
          for (int i = 1; i < FETCH_LATENCY; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_tapd = r_dly[FETCH_LATENCY-1];
    end
  endgenerate

  assign {w_vis_d, w_hs_d, w_vs_d, w_fs_d, w_hd, w_vd} = w_tapd;

  // Without a delay line the origin pixel is coloured in the same clock that samples mode.
  assign w_mode_use = ((FETCH_LATENCY == 0) && w_fs_d) ? mode : r_mode_active;
  assign w_bar_raw  = w_hd / c_BAR_W;
  assign w_bar      = (w_bar_raw > 11'd7) ? 3'd7 : w_bar_raw[2:0];
  assign w_edge     = (w_hd == 11'd0) || (w_hd == 11'(H_VISIBLE - 1)) ||
                      (w_vd == 11'd0) || (w_vd == 11'(V_VISIBLE - 1));

  always_comb begin
    w_rgb = '0;
    if (w_vis_d) begin
      case (w_mode_use)
        2'd0:    w_rgb = fetch.pixel;
        2'd1:    w_rgb = {{COLOR_BITS{~w_bar[1]}}, {COLOR_BITS{~w_bar[2]}}, {COLOR_BITS{~w_bar[0]}}};
        2'd2:    w_rgb = w_edge ? border_color : fetch.pixel;
        default: w_rgb = '0;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
      HS          <= ~c_HS_ACT;
      VS          <= ~c_VS_ACT;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      blank_n     <= w_vis_d;
      frame_start <= w_fs_d;
      HS          <= w_hs_d ? c_HS_ACT : ~c_HS_ACT;
      VS          <= w_vs_d ? c_VS_ACT : ~c_VS_ACT;
      {red, green, blue} <= w_rgb;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_display_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vga_display_controller                                        |
// | Randomised bench with a raster-arithmetic reference model        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_vga_display_controller;

  localparam int HV = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VV = 4, VF = 1, VSW = 1, VB = 1;
  localparam int FL = 2;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam int D  = FL + 1;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] border_color = 24'h123456;
  logic        frame_start, blank_n, HS, VS;
  logic [7:0]  red, green, blue;

  vga_display_controller_if #(.COLOR_BITS(8)) vif ();

  vga_display_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(0), .VS_POL(0), .COLOR_BITS(8), .FETCH_LATENCY(FL)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .mode(mode), .border_color(border_color),
    .fetch(vif), .frame_start(frame_start), .blank_n(blank_n),
    .HS(HS), .VS(VS), .red(red), .green(green), .blue(blue)
  );

  always #5 vga_clk = ~vga_clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          seg = 0;
  logic [23:0] mem [32];
  logic [1:0]  fmode [128];
  logic [23:0] bord_hist [8192];
  logic        req_hist [8192];
  logic [31:0] addr_hist [8192];
  logic [23:0] bars_lit [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int first_blank = -1, fs_prev = -1, fs_period = -1, hs_low = 0, vs_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, segment %0d)", name, act, exp, cyc, seg);
    end
  endtask

  function automatic logic [23:0] bar_color(input int col);
    int b;
    logic r, g, bl;
    b  = col / (HV / 8);
    if (b > 7) b = 7;
    r  = ((b / 2) % 2) == 0;
    g  = b < 4;
    bl = (b % 2) == 0;
    return {{8{r}}, {8{g}}, {8{bl}}};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_blank_n"}, blank_n, 0);
    check({tag, "_rgb"}, {red, green, blue}, 0);
    check({tag, "_hs"}, HS, 1);
    check({tag, "_vs"}, VS, 1);
    check({tag, "_frame_start"}, frame_start, 0);
  endtask

  // Model: request n is raster position n mod FT; its outputs appear D clocks later.
  task automatic compare();
    int p, h, v, t, q, hq, vq;
    logic vis;
    logic [23:0] exp_rgb;
    p = cyc % FT; h = p % HT; v = p / HT;
    vis = (h < HV) && (v < VV);
    check("pixel_req", vif.pixel_req, vis);
    check("next_pixel_h", vif.next_pixel_h, h);
    check("next_pixel_v", vif.next_pixel_v, v);
    check("next_pixel_addr", vif.next_pixel_addr, vis ? v * HV + h : 0);
    req_hist[cyc]  = vif.pixel_req;
    addr_hist[cyc] = vif.next_pixel_addr;
    if (cyc < D) begin
      check_reset_values("startup");
    end else begin
      t = cyc - D; q = t % FT; hq = q % HT; vq = q / HT;
      vis = (hq < HV) && (vq < VV);
      exp_rgb = 24'h0;
      if (vis) begin
        case (fmode[t / FT])
          2'd0: exp_rgb = mem[vq * HV + hq];
          2'd1: exp_rgb = bar_color(hq);
          2'd2: exp_rgb = (hq == 0 || hq == HV - 1 || vq == 0 || vq == VV - 1) ?
                          bord_hist[t + FL] : mem[vq * HV + hq];
          default: exp_rgb = 24'h0;
        endcase
      end
      check("blank_n", blank_n, vis);
      check("frame_start", frame_start, q == 0);
      check("HS", HS, !(hq >= HV + HF && hq < HV + HF + HSW));
      check("VS", VS, !(vq >= VV + VF && vq < VV + VF + VSW));
      check("rgb", {red, green, blue}, exp_rgb);
    end
  endtask

  task automatic drive();
    if (cyc >= FL && req_hist[cyc - FL]) vif.pixel = mem[addr_hist[cyc - FL][4:0]];
    else vif.pixel = 24'($urandom);
  endtask

  // Hand-computed expectations for the first segment.
  task automatic pins();
    if (seg != 0) return;
    if (blank_n && first_blank < 0) first_blank = cyc;
    if (cyc >= D && cyc < D + HT && !HS) hs_low++;
    if (cyc >= D && cyc < D + FT && !VS) vs_low++;
    if (frame_start) begin
      if (fs_prev >= 0 && fs_period < 0) fs_period = cyc - fs_prev;
      fs_prev = cyc;
    end
    if (cyc == 12) check("hs_before_start", HS, 1);
    if (cyc == 13) check("hs_start", HS, 0);
    if (cyc == 17) check("line1_first", {red, green, blue}, 24'h010008);
    if (cyc == 24) check("line1_last", {red, green, blue}, 24'h01000F);
    if (cyc >= 199 && cyc < 207) check("bar_literal", {red, green, blue}, bars_lit[cyc - 199]);
    if (cyc == 300) check("border_top", {red, green, blue}, 24'h123456);
    if (cyc == 314) check("border_interior", {red, green, blue}, 24'h01000B);
    if (cyc == 444) check("pass_after_change", {red, green, blue}, 24'h01001F);
    if (cyc == 493) begin
      check("black_frame_start", frame_start, 1);
      check("black_rgb", {red, green, blue}, 0);
    end
  endtask

  task automatic tick();
    if (cyc % FT == 0) fmode[cyc / FT] = mode;
    bord_hist[cyc] = border_color;
    @(posedge vga_clk);
    cyc++;
    @(negedge vga_clk);
    compare();
    drive();
    pins();
  endtask

  task automatic release_reset();
    @(negedge vga_clk);
    reset = 1'b1;
    cyc = 0;
    compare();
    drive();
  endtask

  task automatic random_run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      if ($urandom_range(39) == 0) mode = 2'($urandom);
      if ($urandom_range(29) == 0) border_color = 24'($urandom);
      tick();
    end
  endtask

  initial begin
    vif.pixel = 24'h0;
    for (int i = 0; i < 32; i++) mem[i] = 24'h010000 + 24'(i);
    repeat (3) @(negedge vga_clk);
    check_reset_values("in_reset");

    release_reset();
    check("first_req_addr", vif.next_pixel_addr, 0);
    repeat (2 * FT) tick();
    check("first_blank_clk", first_blank, D);
    check("hs_low_line0", hs_low, HSW);
    check("vs_low_frame", vs_low, VSW * HT);
    check("frame_period", fs_period, FT);

    mode = 2'd1;
    repeat (FT) tick();
    mode = 2'd2;
    border_color = 24'h123456;
    repeat (FT) tick();
    mode = 2'd0;
    repeat (FT / 2) tick();
    mode = 2'd3;
    repeat (FT / 2) tick();
    repeat (FT) tick();
    random_run(6 * FT);

    for (int k = 0; k < HT && (cyc % HT) != 5; k++) tick();
    #2 reset = 1'b0;
    #1 check_reset_values("async_reset");
    check("async_reset_h", vif.next_pixel_h, 0);
    seg = 1;
    for (int i = 0; i < 32; i++) mem[i] = 24'($urandom);
    repeat (2) @(negedge vga_clk);
    release_reset();
    random_run(5 * FT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_display_controller.md
# vga_display_controller

Parametrised successor to the fixed 640x480 VGA output stage. It generates raster timing from per-phase parameters and issues pixel fetch requests ahead of the beam. A configurable fetch-latency pipeline keeps HS/VS/blank_n aligned with returning pixel data. An output mux selects, per frame, between framebuffer pass-through, a built-in colour-bar test pattern, a bordered overlay, or forced black. It sits between the framebuffer/pixel source and the DAC/HDMI encoder.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch, clocks
- H_SYNC, 96, horizontal sync width, clocks
- H_BACK, 48, horizontal back porch, clocks
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BACK, 33, vertical back porch, lines
- HS_POL, 0, HS active level (0 = active-low)
- VS_POL, 0, VS active level
- COLOR_BITS, 8, bits per colour channel
- FETCH_LATENCY, 1, clocks from request to valid `pixel` (range 0..8)

Ports:
- vga_clk  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-low reset
- mode  in  2  0 pass-through, 1 colour bars, 2 border, 3 black
- border_color  in  3*COLOR_BITS  {r,g,b} used in mode 2
- pixel  in  3*COLOR_BITS  {r,g,b}, valid FETCH_LATENCY clocks after its request
- pixel_req  out  1  high when next_pixel_h/v address a visible pixel
- next_pixel_h  out  11  requested column
- next_pixel_v  out  11  requested line
- next_pixel_addr  out  32  v*H_VISIBLE + h, linear address of the request
- frame_start  out  1  one-clock pulse aligned with the first visible output pixel of each frame
- blank_n  out  1  high during visible output pixels
- HS  out  1  horizontal sync
- VS  out  1  vertical sync
- red, green, blue  out  COLOR_BITS each  output colour

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1). h increments every clock and wraps to 0. v increments when h wraps and itself wraps to 0 after V_TOTAL-1.
- Visible when h<H_VISIBLE and v<V_VISIBLE. pixel_req = visible.
- next_pixel_h/v = h/v, unconditionally.
- next_pixel_addr = v*H_VISIBLE+h when visible, else 0.
- Sync phases:
  - HS is active for H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
  - VS is active for V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC.
  - Active level is HS_POL/VS_POL; the inactive level is its complement.
- Mode is sampled into mode_active only when h=0 and v=0, so changes never tear mid-frame. mode_active resets to 0.
- Colour selection for a visible pixel, using the delayed coordinates (hd, vd):
  - mode 0: `pixel`.
  - mode 1: bar index b = min(7, hd / (H_VISIBLE/8)). Colours for b=0..7: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or zero.
  - mode 2: border_color when hd=0, hd=H_VISIBLE-1, vd=0 or vd=V_VISIBLE-1; otherwise `pixel`.
  - mode 3: 0.
- Non-visible pixels always output 0, in every mode.

## Timing
- Pipeline depth D = FETCH_LATENCY+1.
- visible, HS, VS, hd, vd and the frame-start flag pass through a D-1 stage delay line.
- `pixel` is sampled in the same clock as the delayed flags (request clock + FETCH_LATENCY).
- Colour, blank_n, HS, VS and frame_start are registered once more. All are therefore valid at request clock + D, mutually aligned.
- pixel_req, next_pixel_h, next_pixel_v and next_pixel_addr are combinational from the counters, with zero latency.
- Reset (asserted low, async):
  - h=v=0; all delay stages cleared.
  - blank_n=0, red/green/blue=0, frame_start=0.
  - HS=~HS_POL, VS=~VS_POL; mode_active=0.
- First clock edge after release: counters hold (0,0) for that cycle, so the first request is (0,0), addr 0. The first blank_n=1 follows D clocks later, together with frame_start.
- Reset mid-frame: all outputs return to reset values immediately. The delay line is flushed, so no stale pixel is emitted after release.
- Wrap: at h=H_TOTAL-1, v=V_TOTAL-1 the next clock is (0,0) and mode is resampled.
- With FETCH_LATENCY=0, `pixel` must be valid combinationally in the request clock.

## Test plan
Small test parameters: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), FETCH_LATENCY=2, COLOR_BITS=8.

- Reset held, then released → blank_n=0, rgb=0, HS=VS=1 during reset. The first request is (0,0) with addr 0. blank_n rises exactly 3 clocks after release, with frame_start=1 for one clock.
- Mode 0, source returns pixel = 24'h010000+addr two clocks after each request → output line 1 reads 0x010008..0x01000F, and HS low for exactly 2 clocks starting 10+3 clocks after line start. Frame period = 98 clocks; VS low for exactly 14 clocks per frame.
- Mode 1 → columns 0..7 output FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; blank periods are 0.
- Mode 2, border_color=24'h123456 → all of row 0, row 3, column 0 and column 7 output 123456; interior pixels equal the source pixel.
- Mode changed from 0 to 3 mid-frame → the current frame stays pass-through. Output is 0 from the first pixel of the next frame, and frame_start still pulses.
- Reset pulsed low mid-line → outputs go to reset values asynchronously, with no nonzero rgb emitted after release before the first new blank_n.
